// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 5x4 active-low key matrix one column at a time,
// debounces whole-scan readings and reports each accepted press once.
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] row,
    output logic [3:0] col,
    output logic       newKey,
    output logic [4:0] keycode
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             slot_end;
    logic             eval_p;
    logic [4:0]       row_meta;
    logic [4:0]       row_sync;
    logic [3:0][4:0]  snap;
    logic [4:0]       n_down;
    logic [4:0]       hit_code;
    logic             read_none;
    logic             read_single;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_cnt_n;
    logic [4:0]       cand;
    logic [4:0]       cand_n;
    logic             report;

    function automatic logic [4:0] key_code(input int r, input int c);
        if (r < 4) key_code = {1'b1, 4'(4 * r + c)};
        else       key_code = 5'(c + 1);
    endfunction

    assign slot_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign col      = ~(4'b0001 << col_idx);

    // Free-running column scan; independent of the debounce state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            col_idx <= '0;
            eval_p  <= 1'b0;
        end else begin
            eval_p <= slot_end && (col_idx == 2'd3);
            if (slot_end) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta <= 5'b11111;
            row_sync <= 5'b11111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Every column group is rewritten once per scan before it is evaluated,
    // so the snapshot needs no reset.
    always_ff @(posedge clock) begin
        if (slot_end) snap[col_idx] <= ~row_sync;
    end

    always_comb begin
        n_down   = '0;
        hit_code = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 5; r++) begin
                if (snap[c][r]) begin
                    n_down   = n_down + 5'd1;
                    hit_code = key_code(r, c);
                end
            end
        end
    end

    assign read_none   = (n_down == 5'd0);
    assign read_single = (n_down == 5'd1);

    always_comb begin
        state_n    = state;
        stab_cnt_n = stab_cnt;
        cand_n     = cand;
        report     = 1'b0;
        if (eval_p) begin
            case (state)
                IDLE: begin
                    if (read_single) begin
                        cand_n     = hit_code;
                        stab_cnt_n = CNT_W'(1);
                        state_n    = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (read_single && (hit_code == cand)) begin
                        if (stab_cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            report     = 1'b1;
                            stab_cnt_n = '0;
                            state_n    = HELD;
                        end else begin
                            stab_cnt_n = stab_cnt + CNT_W'(1);
                        end
                    end else begin
                        stab_cnt_n = '0;
                        state_n    = IDLE;
                    end
                end
                HELD: begin
                    if (read_none) begin
                        stab_cnt_n = CNT_W'(1);
                        state_n    = REL_DB;
                    end
                end
                REL_DB: begin
                    if (read_none) begin
                        if (stab_cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            stab_cnt_n = '0;
                            state_n    = IDLE;
                        end else begin
                            stab_cnt_n = stab_cnt + CNT_W'(1);
                        end
                    end else begin
                        stab_cnt_n = '0;
                        state_n    = HELD;
                    end
                end
                default: begin
                    stab_cnt_n = '0;
                    state_n    = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            stab_cnt <= '0;
            cand     <= '0;
            newKey   <= 1'b0;
            keycode  <= '0;
        end else begin
            state    <= state_n;
            stab_cnt <= stab_cnt_n;
            cand     <= cand_n;
            newKey   <= report;
            if (report) keycode <= cand;
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans the calculator's 5×4 key matrix and debounces it.
- Produces the `newKey` / `keycode` pair consumed by the calculator logic: a one-cycle `newKey` pulse per debounced key press, with a 5-bit `keycode` in {num, data} format.
- Sits between the board's keypad pins and the calculator logic; it is the only block that touches the matrix pins.

## Interface

Parameters:
- `SCAN_DIV`, default 25000: clock cycles each column is driven. Minimum 4.
- `DEBOUNCE_SCANS`, default 10: consecutive full scans a reading must be stable before it is accepted. Minimum 2.

Ports:
- `clock`  input  1  System clock; single clock domain.
- `reset`  input  1  Asynchronous, active-low reset (asserted when 0).
- `row`  input  5  Matrix rows. Active-low; pulled up on the board; asynchronous to `clock`.
- `col`  output  4  Matrix column drive. Active-low; exactly one bit low at any time.
- `newKey`  output  1  High for exactly one cycle per accepted key press.
- `keycode`  output  5  Code of the last accepted key. Valid during `newKey`; held until the next press.

## Operation

Key map (row r, col c):
- Rows 0–3: hex digit d = 4r + c; keycode = {1'b1, d[3:0]}.
- Row 4: c0 = AC (5'b00001), c1 = PLUS (5'b00010), c2 = MUL (5'b00011), c3 = EQUALS (5'b00100).

Scanning:
- `row` passes through a 2-flop synchroniser.
- Column index cycles 0→1→2→3→0. Each column is held for `SCAN_DIV` cycles.
- The synchronised rows are sampled on the last cycle of each column slot.
- A full scan is 4·`SCAN_DIV` cycles. The scan cycles continuously and does not depend on state.

Scan evaluation, once per scan, in the cycle after the column-3 sample:
- Exactly one key down → reading = that key.
- No key down → reading = NONE.
- More than one key down → reading = MULTI.

Debounce FSM (a stability counter counts consecutive scans with an identical reading, including the first; it is cleared on every state change):
- IDLE: on a single-key reading, capture it as the candidate and go to PRESS_DB (count = 1). NONE and MULTI readings stay in IDLE.
- PRESS_DB:
  - Reading equals candidate → increment count.
  - Count reaches `DEBOUNCE_SCANS` → load `keycode` = candidate, pulse `newKey` for one cycle, go to HELD.
  - Any other reading → return to IDLE.
- HELD: no reports. A NONE reading goes to REL_DB (count = 1). Any other reading (including a different key or MULTI) stays in HELD.
- REL_DB: count NONE readings. When count reaches `DEBOUNCE_SCANS` → IDLE. Any non-NONE reading → HELD.

Other rules:
- No auto-repeat. A second key pressed while the first is held is never reported.
- Releasing all keys and pressing again requires a full release debounce before the new press is accepted.
- Reset mid-operation discards any partial debounce; no pulse is generated for it. A key still held when reset deasserts is reported after a fresh full press debounce from scan 0.

## Timing

Reset values:
- `col` = 4'b1110 (column 0 driven).
- `newKey` = 0, `keycode` = 5'b00000.
- FSM = IDLE; scan, column, and stability counters = 0; synchroniser flops = 5'b11111.

Cycle timing:
- `newKey` and the new `keycode` appear in the cycle after the evaluation that reaches the threshold. `keycode` changes only in that cycle.
- Press latency from the first scan that sees a stable key: (`DEBOUNCE_SCANS` − 1) full scans + ≤ 2 cycles.
- `newKey` never asserts on two consecutive cycles. Minimum spacing between pulses is 2·`DEBOUNCE_SCANS` scans.
- A row change inside a column slot less than 2 cycles before the sample point may be missed; it is taken on the next scan.

## Test plan

All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3 (scan = 16 cycles).

1. Assert `reset` low mid-scan → `col`=1110, `newKey`=0, `keycode`=00000 immediately. After release, `col` steps 1110→1101→1011→0111 every 4 cycles.
2. Hold digit 7 (row 1, col 3) for 30 scans → exactly one `newKey` pulse with `keycode`=10111, 2 scans after the first detecting scan. No further pulses while held.
3. Toggle key 0 (row 0, col 0) every 5 cycles for 3 scans, then hold it → no pulse during bouncing. One pulse with `keycode`=10000 after 3 stable scans.
4. Press AC, release, press PLUS, release, press MUL, release, press EQUALS → pulses with `keycode` = 00001, 00010, 00011, 00100 in order.
5. Press digits 1 and 2 together from IDLE → no pulse. Release digit 1 → one pulse with `keycode`=10010. Then press digit 5 while 2 is still held → no pulse.
6. Hold digit F; assert `reset` during PRESS_DB count 2 → no pulse. After release of `reset` with F still held → one pulse with `keycode`=11111 after 3 new scans.
